// File: rtl/arc4_key_search.sv
// rtl/arc4_key_search.sv - ARC4 key-search controller driving arc4 and checking pt_mem
//
// Walks candidate keys from KEY_FIRST in steps of KEY_STEP (never past KEY_LAST).
// For each key it starts arc4, waits for it to finish, then reads the
// length-prefixed plaintext from pt_mem. It stops at the first key whose
// plaintext bytes are all printable ASCII (8'h20..8'h7E).
//
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   en           start request, honoured only while rdy=1
//   rdy          idle / able to accept en
//   key          current candidate, and the result once done
//   key_valid    key holds a key whose plaintext passed the check
//   arc_en       one-cycle start pulse to arc4
//   arc_rdy      arc4 ready
//   arc_key      key driven to arc4 (always equals key)
//   pt_addr      pt_mem read address
//   pt_rddata    pt_mem read data (1-cycle synchronous read)

module arc4_key_search #(
  parameter logic [23:0] KEY_FIRST = 24'h000000,
  parameter logic [23:0] KEY_LAST  = 24'hFFFFFF,
  parameter logic [23:0] KEY_STEP  = 24'h000001
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  output logic        rdy,
  output logic [23:0] key,
  output logic        key_valid,
  output logic        arc_en,
  input  logic        arc_rdy,
  output logic [23:0] arc_key,
  output logic [7:0]  pt_addr,
  input  logic [7:0]  pt_rddata
);

  typedef enum logic [2:0] {
    IDLE,
    LAUNCH,
    BUSY,
    RUN,
    RD_LEN,
    SCAN,
    DONE
  } state_t;

  state_t      state;
  logic [7:0]  len;
  logic [7:0]  idx;
  // 0: address presented, memory capturing; 1: pt_rddata valid this cycle
  logic        phase;

  // 25-bit sum so both "key == KEY_LAST" and 24-bit overflow end the search,
  // and KEY_STEP > KEY_LAST cannot underflow the comparison.
  logic [24:0] key_next;
  logic        last_key;
  logic        byte_ok;

  assign key_next = {1'b0, key} + {1'b0, KEY_STEP};
  assign last_key = (key_next > {1'b0, KEY_LAST});
  assign byte_ok  = (pt_rddata >= 8'h20) && (pt_rddata <= 8'h7E);
  assign arc_key  = key;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      rdy       <= 1'b1;
      key       <= KEY_FIRST;
      key_valid <= 1'b0;
      arc_en    <= 1'b0;
      pt_addr   <= 8'd0;
      len       <= 8'd0;
      idx       <= 8'd0;
      phase     <= 1'b0;
    end else begin
      arc_en <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (en) begin
            state     <= LAUNCH;
            key       <= KEY_FIRST;
            key_valid <= 1'b0;
            rdy       <= 1'b0;
          end
        end
        LAUNCH: begin
          if (arc_rdy) begin
            arc_en <= 1'b1;
            state  <= BUSY;
          end
        end
        // arc4 may keep rdy high for a cycle after en; wait for it to drop
        BUSY: begin
          if (!arc_rdy) state <= RUN;
        end
        RUN: begin
          if (arc_rdy) begin
            state   <= RD_LEN;
            pt_addr <= 8'd0;
            phase   <= 1'b0;
          end
        end
        RD_LEN: begin
          if (!phase) begin
            phase <= 1'b1;
          end else begin
            phase <= 1'b0;
            len   <= pt_rddata;
            if (pt_rddata == 8'd0) begin
              state     <= DONE;
              key_valid <= 1'b1;
              rdy       <= 1'b1;
            end else begin
              idx     <= 8'd1;
              pt_addr <= 8'd1;
              state   <= SCAN;
            end
          end
        end
        SCAN: begin
          if (!phase) begin
            phase <= 1'b1;
          end else begin
            phase <= 1'b0;
            if (!byte_ok) begin
              if (last_key) begin
                state <= DONE;
                rdy   <= 1'b1;
              end else begin
                key   <= key_next[23:0];
                state <= LAUNCH;
              end
            end else if (idx == len) begin
              state     <= DONE;
              key_valid <= 1'b1;
              rdy       <= 1'b1;
            end else begin
              // idx < len <= 255 here, so the increment never wraps
              idx     <= idx + 8'd1;
              pt_addr <= idx + 8'd1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_arc4_key_search.sv
// tb/tb_arc4_key_search.sv - scoreboard bench for arc4_key_search

module tb_arc4_key_search;

  localparam int N = 3;
  // instance 0: single pass / handshake, 1: exhaustion, 2: single-key boundaries
  localparam logic [N-1:0][23:0] KF = {24'h000010, 24'hFFFFFD, 24'h1E45FE};
  localparam logic [N-1:0][23:0] KL = {24'h000010, 24'hFFFFFF, 24'hFFFFFF};
  localparam logic [N-1:0][23:0] KS = {24'h000001, 24'h000002, 24'h000001};

  localparam int K_LAUNCH = 0;
  localparam int K_SCAN   = 1;
  localparam int K_DONE   = 2;

  logic clk = 1'b0;
  logic clk_run;
  logic rst_n;

  logic [N-1:0]       en_v, rdy_v, key_valid_v, arc_en_v, arc_rdy_v;
  logic [N-1:0][23:0] key_v, arc_key_v;
  logic [N-1:0][7:0]  pt_addr_v, pt_rddata_v;

  logic [23:0] pass_key;
  logic [7:0]  pass_msg [256];
  logic [7:0]  fail_msg [256];

  typedef struct {
    int          kind;
    logic [23:0] key;
    logic        valid;
    logic [7:0]  maxa;
  } exp_t;

  exp_t sb[$];

  int total, bad, done_cnt, sel;
  logic mon_en, prev_rdy, win_open, seen_low;
  int hi_cnt;
  logic [7:0] maxa;

  logic [7:0] bvals [4];
  logic       bok   [4];

  always begin
    #5;
    if (clk_run) clk = ~clk;
  end

  for (genvar g = 0; g < N; g++) begin : g_dut
    logic        a_rdy;
    logic [4:0]  cnt;
    logic [23:0] cur_key;
    logic [7:0]  q;

    assign arc_rdy_v[g]   = a_rdy;
    assign pt_rddata_v[g] = q;

    arc4_key_search #(
      .KEY_FIRST(KF[g]),
      .KEY_LAST (KL[g]),
      .KEY_STEP (KS[g])
    ) u_dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .en       (en_v[g]),
      .rdy      (rdy_v[g]),
      .key      (key_v[g]),
      .key_valid(key_valid_v[g]),
      .arc_en   (arc_en_v[g]),
      .arc_rdy  (arc_rdy_v[g]),
      .arc_key  (arc_key_v[g]),
      .pt_addr  (pt_addr_v[g]),
      .pt_rddata(pt_rddata_v[g])
    );

    // arc4 stub: drops rdy for 20 cycles after each start
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        a_rdy   <= 1'b1;
        cnt     <= 5'd0;
        cur_key <= 24'd0;
      end else if (arc_en_v[g]) begin
        a_rdy   <= 1'b0;
        cnt     <= 5'd20;
        cur_key <= arc_key_v[g];
      end else if (cnt != 5'd0) begin
        cnt <= cnt - 5'd1;
        if (cnt == 5'd1) a_rdy <= 1'b1;
      end
    end

    // pt_mem model: 1-cycle synchronous read of the plaintext for the last key
    always_ff @(posedge clk) begin
      q <= (cur_key == pass_key) ? pass_msg[pt_addr_v[g]] : fail_msg[pt_addr_v[g]];
    end
  end

  task automatic push(input int kind, input logic [23:0] k, input logic v, input logic [7:0] m);
    exp_t e;
    e.kind  = kind;
    e.key   = k;
    e.valid = v;
    e.maxa  = m;
    sb.push_back(e);
  endtask

  task automatic push_run(input logic [23:0] k, input logic [7:0] m);
    push(K_LAUNCH, k, 1'b0, 8'd0);
    push(K_SCAN, 24'd0, 1'b0, m);
  endtask

  task automatic sb_check(input int kind, input logic [23:0] k, input logic v, input logic [7:0] m);
    exp_t e;
    logic ok;
    total++;
    if (sb.size() == 0) begin
      bad++;
      $display("FAIL sb_unexpected actual kind=%0d key=%h valid=%b maxaddr=%0d required no event",
               kind, k, v, m);
      return;
    end
    e = sb.pop_front();
    if (e.kind != kind) ok = 1'b0;
    else if (kind == K_LAUNCH) ok = (k === e.key);
    else if (kind == K_SCAN) ok = (m === e.maxa);
    else ok = (k === e.key) && (v === e.valid);
    if (!ok) begin
      bad++;
      $display("FAIL sb_event actual kind=%0d key=%h valid=%b maxaddr=%0d required kind=%0d key=%h valid=%b maxaddr=%0d",
               kind, k, v, m, e.kind, e.key, e.valid, e.maxa);
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  task automatic wait_done(input int n, input int budget);
    int k;
    k = 0;
    while (done_cnt < n && k < budget) begin
      @(negedge clk);
      k++;
    end
    total++;
    if (done_cnt < n) begin
      bad++;
      $display("FAIL done_timeout actual=%0d required=%0d", done_cnt, n);
    end
  endtask

  task automatic pulse_en(input int i);
    en_v[i] = 1'b1;
    @(negedge clk);
    en_v[i] = 1'b0;
  endtask

  task automatic sb_drained(input string name);
    chk(name, sb.size(), 0);
    sb.delete();
  endtask

  // Monitor: every arc_en and every rdy rise of the selected instance is an
  // event; the largest pt_addr read in a decrypt window is checked when it closes.
  always @(negedge clk) begin
    if (mon_en) begin
      if (!arc_rdy_v[sel]) begin
        seen_low = 1'b1;
        hi_cnt   = 0;
      end else if (seen_low) begin
        // first arc_rdy-high sample still carries the previous address
        if (hi_cnt > 0 && pt_addr_v[sel] > maxa) maxa = pt_addr_v[sel];
        hi_cnt++;
      end
      if (arc_en_v[sel]) begin
        if (win_open) sb_check(K_SCAN, 24'd0, 1'b0, maxa);
        sb_check(K_LAUNCH, arc_key_v[sel], 1'b0, 8'd0);
        win_open = 1'b1;
        maxa     = 8'd0;
        seen_low = 1'b0;
        hi_cnt   = 0;
      end
      if (rdy_v[sel] && !prev_rdy) begin
        if (win_open) sb_check(K_SCAN, 24'd0, 1'b0, maxa);
        sb_check(K_DONE, key_v[sel], key_valid_v[sel], 8'd0);
        win_open = 1'b0;
        done_cnt++;
      end
      prev_rdy = rdy_v[sel];
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    int n;
    clk_run  = 1'b1;
    rst_n    = 1'b0;
    en_v     = '0;
    sel      = 0;
    mon_en   = 1'b0;
    prev_rdy = 1'b1;
    win_open = 1'b0;
    seen_low = 1'b0;
    hi_cnt   = 0;
    maxa     = 8'd0;
    done_cnt = 0;
    total    = 0;
    bad      = 0;
    pass_key = 24'h123456;
    for (int i = 0; i < 256; i++) begin
      pass_msg[i] = 8'h61;
      fail_msg[i] = 8'h61;
    end
    bvals[0] = 8'h20; bok[0] = 1'b1;
    bvals[1] = 8'h7E; bok[1] = 1'b1;
    bvals[2] = 8'h1F; bok[2] = 1'b0;
    bvals[3] = 8'h7F; bok[3] = 1'b0;

    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // reset mid-SCAN with the clock stopped
    fail_msg[0] = 8'd5;
    pulse_en(0);
    n = 0;
    while (pt_addr_v[0] != 8'd2 && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk("reach_scan", {31'd0, pt_addr_v[0] == 8'd2}, 32'd1);
    clk_run = 1'b0;
    #3;
    rst_n = 1'b0;
    #1;
    chk("rst_rdy", {31'd0, rdy_v[0]}, 32'd1);
    chk("rst_key", {8'd0, key_v[0]}, {8'd0, 24'h1E45FE});
    chk("rst_key_valid", {31'd0, key_valid_v[0]}, 32'd0);
    chk("rst_arc_en", {31'd0, arc_en_v[0]}, 32'd0);
    chk("rst_pt_addr", {24'd0, pt_addr_v[0]}, 32'd0);
    clk_run = 1'b1;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // single pass with early reject; en pulse while busy must be ignored
    fail_msg[1] = 8'h07;
    pass_key    = 24'h1E4600;
    pass_msg[0] = 8'd3;
    pass_msg[1] = 8'h61;
    pass_msg[2] = 8'h62;
    pass_msg[3] = 8'h63;
    push_run(24'h1E45FE, 8'd1);
    push_run(24'h1E45FF, 8'd1);
    push_run(24'h1E4600, 8'd3);
    push(K_DONE, 24'h1E4600, 1'b1, 8'd0);
    mon_en = 1'b1;
    pulse_en(0);
    n = 0;
    while (!arc_en_v[0] && n < 50) begin
      @(negedge clk);
      n++;
    end
    repeat (3) @(negedge clk);
    pulse_en(0);
    wait_done(1, 2000);
    sb_drained("sb_empty_single_pass");

    // en held high across DONE: accepted again only once rdy=1
    for (int r = 0; r < 2; r++) begin
      push_run(24'h1E45FE, 8'd1);
      push_run(24'h1E45FF, 8'd1);
      push_run(24'h1E4600, 8'd3);
      push(K_DONE, 24'h1E4600, 1'b1, 8'd0);
    end
    en_v[0] = 1'b1;
    wait_done(2, 2000);
    n = 0;
    while (rdy_v[0] && n < 20) begin
      @(negedge clk);
      n++;
    end
    en_v[0] = 1'b0;
    wait_done(3, 2000);
    sb_drained("sb_empty_en_held");

    // exhaustion at the top of the key space, step 2, no wrap
    sel      = 1;
    pass_key = 24'h123456;
    push_run(24'hFFFFFD, 8'd1);
    push_run(24'hFFFFFF, 8'd1);
    push(K_DONE, 24'hFFFFFF, 1'b0, 8'd0);
    pulse_en(1);
    wait_done(4, 2000);
    sb_drained("sb_empty_exhaust");

    // printable boundary characters as the last byte of a len=4 message
    sel      = 2;
    pass_key = 24'h000010;
    for (int b = 0; b < 4; b++) begin
      pass_msg[0] = 8'd4;
      pass_msg[1] = 8'h61;
      pass_msg[2] = 8'h62;
      pass_msg[3] = 8'h63;
      pass_msg[4] = bvals[b];
      push_run(24'h000010, 8'd4);
      push(K_DONE, 24'h000010, bok[b], 8'd0);
      pulse_en(2);
      wait_done(5 + b, 1000);
    end
    sb_drained("sb_empty_boundary");

    // len=0 passes on the first key
    pass_msg[0] = 8'd0;
    push_run(24'h000010, 8'd0);
    push(K_DONE, 24'h000010, 1'b1, 8'd0);
    pulse_en(2);
    wait_done(9, 1000);

    // len=255 scans addresses 1..255
    for (int i = 1; i < 256; i++) pass_msg[i] = 8'h7A;
    pass_msg[0] = 8'd255;
    push_run(24'h000010, 8'd255);
    push(K_DONE, 24'h000010, 1'b1, 8'd0);
    pulse_en(2);
    wait_done(10, 2000);
    sb_drained("sb_empty_len_edges");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
